// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO between the fetch PC and the ID stage.
// Prefetches sequential words while imem acknowledges, hands {pc, pc4, ir} to ID
// through a valid/ready handshake and flushes everything on a redirect.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward an acknowledged fetch
// straight to deq_* when the queue is empty (zero-cycle latency).
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [31:0]                imem_addr,
    output logic                       imem_req,
    input  logic [31:0]                imem_data,
    input  logic                       imem_ack_n,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    input  logic                       deq_ready,
    output logic                       deq_valid,
    output logic [31:0]                deq_pc,
    output logic [31:0]                deq_pc4,
    output logic [31:0]                deq_ir,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [31:0]   fetch_pc;
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_next;

    // pc4 is stored alongside pc so a cleared slot reads back as all zeros
    logic [31:0]   mem_pc  [DEPTH];
    logic [31:0]   mem_pc4 [DEPTH];
    logic [31:0]   mem_ir  [DEPTH];

    logic          queue_valid;
    logic          is_full;
    logic          bypass;
    logic          bypass_take;
    logic          push;
    logic          pop;
    logic          fetch_adv;
    logic [31:0]   redirect_target;
    logic          unused_redirect_lsbs;

    assign redirect_target      = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign is_full     = (count_q == DEPTH_C);
    assign queue_valid = (count_q != '0) & ~redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
    // An acknowledged fetch into an empty queue is presented to ID directly.
    assign bypass = (count_q == '0) & (state_q == FETCH) & ~imem_ack_n & ~redirect;
`else
    assign bypass = 1'b0;
`endif

    assign bypass_take = bypass & deq_ready;
    assign deq_valid   = queue_valid | bypass;
    // A bypassed word never occupies a slot, so only queued entries advance rp.
    assign pop         = queue_valid & deq_ready;
    assign fetch_adv   = push | bypass_take;
    assign count_next  = count_q + CW'(push) - CW'(pop);

    assign imem_addr = fetch_pc;
    assign count     = count_q;

    // Next-state, fetch request and push decision.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        push     = 1'b0;
        case (state_q)
            BOOT: begin
                imem_req = 1'b0;
                push     = 1'b0;
            end
            FETCH: begin
                imem_req = 1'b1;
                push     = ~imem_ack_n & ~redirect & (~is_full | pop) & ~bypass_take;
            end
            FULL: begin
                // Fetching resumes only in a cycle where a slot is being freed.
                imem_req = pop;
                push     = pop & ~imem_ack_n & ~redirect;
            end
            default: begin
                imem_req = 1'b0;
                push     = 1'b0;
            end
        endcase

        if (redirect || state_q == BOOT) begin
            state_d = FETCH;
        end else if (count_next == DEPTH_C) begin
            state_d = FULL;
        end else begin
            state_d = FETCH;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch PC, pointers and occupancy; redirect overrides any push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            wp       <= '0;
            rp       <= '0;
            count_q  <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_target;
            wp       <= '0;
            rp       <= '0;
            count_q  <= '0;
        end else begin
            if (fetch_adv) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            count_q <= count_next;
        end
    end

    // Entry storage; cleared on reset so an empty queue reads back zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]  <= '0;
                mem_pc4[i] <= '0;
                mem_ir[i]  <= '0;
            end
        end else if (push) begin
            mem_pc[wp]  <= fetch_pc;
            mem_pc4[wp] <= fetch_pc + 32'd4;
            mem_ir[wp]  <= imem_data;
        end
    end

`ifdef FETCH_QUEUE_BYPASS_EN
    // Head entry, or the in-flight fetch when it is being forwarded.
    always_comb begin
        deq_pc  = mem_pc[rp];
        deq_pc4 = mem_pc4[rp];
        deq_ir  = mem_ir[rp];
        if (bypass) begin
            deq_pc  = fetch_pc;
            deq_pc4 = fetch_pc + 32'd4;
            deq_ir  = imem_data;
        end
    end
`else
    // Head entry of the queue.
    always_comb begin
        deq_pc  = mem_pc[rp];
        deq_pc4 = mem_pc4[rp];
        deq_ir  = mem_ir[rp];
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic,
// compared against a queue-based reference model of the fetch/dequeue rules.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_data;
    logic        imem_ack_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_pc4;
    logic [31:0] deq_ir;
    logic [$clog2(DEPTH):0] count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [63:0] m_q[$];
    logic [31:0] m_fpc;
    bit          m_boot;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_data(imem_data), .imem_ack_n(imem_ack_n),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .deq_ready(deq_ready), .deq_valid(deq_valid),
        .deq_pc(deq_pc), .deq_pc4(deq_pc4), .deq_ir(deq_ir),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Instruction memory: returns a word derived from the requested address
    always_comb imem_data = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fpc  = RESET_PC;
        m_boot = 1'b1;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
    task automatic step(input bit ack, input bit rdy, input bit red, input logic [31:0] rpc);
        int          n;
        bit          byp;
        bit          e_valid;
        bit          e_req;
        bit          pop;
        bit          push;
        logic [31:0] hp;
        logic [31:0] hi;
        imem_ack_n  = ~ack;
        deq_ready   = rdy;
        redirect    = red;
        redirect_pc = rpc;
        @(negedge clk);
        n   = m_q.size();
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (n == 0) && !m_boot && ack && !red;
`endif
        e_valid = ((n != 0) && !red) || byp;
        if (m_boot)          e_req = 1'b0;
        else if (n < DEPTH)  e_req = 1'b1;
        else                 e_req = !red && rdy;
        chk("imem_addr", imem_addr, m_fpc);
        chk("imem_req", 32'(imem_req), 32'(e_req));
        chk("count", 32'(count), 32'(n));
        chk("deq_valid", 32'(deq_valid), 32'(e_valid));
        if (e_valid) begin
            if (byp) begin
                hp = m_fpc;
                hi = mem_word(m_fpc);
            end else begin
                hp = m_q[0][63:32];
                hi = m_q[0][31:0];
            end
            chk("deq_pc", deq_pc, hp);
            chk("deq_pc4", deq_pc4, hp + 32'd4);
            chk("deq_ir", deq_ir, hi);
        end
        if (red) begin
            m_q.delete();
            m_fpc  = {rpc[31:2], 2'b00};
            m_boot = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (byp && rdy) begin
            m_fpc = m_fpc + 32'd4;
        end else begin
            pop  = (n > 0) && rdy;
            push = ack && ((n < DEPTH) || pop);
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back({m_fpc, mem_word(m_fpc)});
                m_fpc = m_fpc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        imem_ack_n  = 1'b1;
        deq_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #1;
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(deq_valid), 32'd0);
        chk("rst_pc", deq_pc, 32'd0);
        chk("rst_pc4", deq_pc4, 32'd0);
        chk("rst_ir", deq_ir, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Streaming with ack and ready held: one instruction per cycle
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0);

        // Stall ID until the queue fills, then drain with concurrent refill
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);

        // Imem wait states at 0x10 with an empty queue, then acknowledge
        step(0, 1, 1, 32'h0000_0010);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);

        // Three queued entries, then redirect to an unaligned target
        step(0, 1, 1, 32'h0000_0100);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(1, 0, 1, 32'h0000_0203);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);

        // Redirect coinciding with a pop and a push
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 1, 32'h8000_0040);
        step(0, 1, 0, 0);

        // Redirect while full, and fetch wrap at the top of the address space
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
        step(1, 0, 1, 32'hFFFF_FFF8);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 29) == 0, $urandom);
        end

        // Asynchronous reset with two entries queued
        step(0, 0, 1, 32'h0000_0400);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(deq_valid), 32'd0);
        chk("arst_addr", imem_addr, RESET_PC);
        chk("arst_req", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
